// File: rtl/pump_array_ctrl_pkg.sv
// Shared types and constants for the pump array controller: channel FSM
// state encoding, register map and register reset values.
package pump_array_ctrl_pkg;

  // Per-channel FSM states. The encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ON_HOLD  = 3'd1,
    ST_ON       = 3'd2,
    ST_OFF_HOLD = 3'd3,
    ST_FAULT    = 3'd4
  } chan_state_t;

  // Register map (2-bit address space, every address populated).
  localparam logic [1:0] ADDR_REQ    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_FAULT  = 2'd2;
  localparam logic [1:0] ADDR_ENABLE = 2'd3;

  // Register reset values, before truncation to the channel count.
  localparam logic [7:0] REQ_RST    = 8'h00;
  localparam logic [7:0] FAULT_RST  = 8'h00;
  localparam logic [7:0] ENABLE_RST = 8'hFF;
  localparam logic [7:0] DOUT_RST   = 8'h00;

  // Keeps only the low n bits of a register byte; the upper bits read as 0.
  function automatic logic [7:0] low_bits(input logic [7:0] v, input int n);
    logic [7:0] mask;
    mask = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b < n) mask[b] = 1'b1;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/pump_array_ctrl_if.sv
// Peripheral bus interface for the pump array controller.
//
// Bus semantics: write and read are single-cycle strobes sampled on the
// rising clock edge; there is no back-pressure, so every strobe is accepted
// on the edge that samples it. A write updates the addressed register on
// that edge. A read captures the addressed register into dataOut on that
// edge; dataOut then holds until the next read. When read and write hit
// the same edge, the write lands and dataOut carries the pre-write value.
interface pump_array_ctrl_if;
  logic       write;
  logic       read;
  logic [1:0] address;
  logic [7:0] dataIn;
  logic [7:0] dataOut;

  modport master (
    output write,
    output read,
    output address,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  write,
    input  read,
    input  address,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/pump_array_ctrl_channel.sv
// One pump channel: hold-time FSM with a shared hold/run counter and a
// run watchdog. The counter restarts on entry to ON_HOLD and keeps counting
// through ON, so it measures both the min-on time and the total run time.
// At the end of a hold period the FSM moves straight to the state the
// current go level asks for, so a pump that is dropped or re-requested
// during a hold stays on/off for exactly the hold length.
module pump_array_ctrl_channel
  import pump_array_ctrl_pkg::*;
#(
  parameter int MIN_ON_CYC  = 16,
  parameter int MIN_OFF_CYC = 16,
  parameter int MAX_ON_CYC  = 1024,
  parameter int CNT_W       = $clog2(MAX_ON_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        fault_clr,
  output logic        on,
  output logic        fault_set,
  output chan_state_t state
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST     = CNT_W'(MAX_ON_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             running;
  logic             watchdog;

  // Saturating increment so the counter can never wrap.
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign running  = (state == ST_ON_HOLD) || (state == ST_ON);
  assign watchdog = running && (cnt == RUN_LAST);

  // Raised in the cycle the FSM is about to enter FAULT, so the top can set
  // the fault flag on the same edge.
  assign fault_set = watchdog;

  // Channel FSM with registered pump drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      on    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (go) begin
            state <= ST_ON_HOLD;
            cnt   <= '0;
            on    <= 1'b1;
          end
        end
        ST_ON_HOLD: begin
          if (watchdog) begin
            state <= ST_FAULT;
            cnt   <= '0;
            on    <= 1'b0;
          end else if (cnt == MIN_ON_LAST) begin
            if (go) begin
              state <= ST_ON;
              cnt   <= cnt_inc;
            end else begin
              state <= ST_OFF_HOLD;
              cnt   <= '0;
              on    <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_ON: begin
          // Watchdog expiry takes priority over a simultaneous stop.
          if (watchdog) begin
            state <= ST_FAULT;
            cnt   <= '0;
            on    <= 1'b0;
          end else if (!go) begin
            state <= ST_OFF_HOLD;
            cnt   <= '0;
            on    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_OFF_HOLD: begin
          if (cnt == MIN_OFF_LAST) begin
            if (go) begin
              state <= ST_ON_HOLD;
              cnt   <= '0;
              on    <= 1'b1;
            end else begin
              state <= ST_OFF;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state <= ST_OFF_HOLD;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          on    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pump_array_ctrl.sv
// Register-mapped controller for an array of pump actuators. Holds the
// REQ / FAULT / ENABLE registers, the registered read mux and the fault
// interrupt, and instantiates one hold-time FSM per channel.
module pump_array_ctrl
  import pump_array_ctrl_pkg::*;
#(
  parameter int NUM_PUMPS   = 4,
  parameter int MIN_ON_CYC  = 16,
  parameter int MIN_OFF_CYC = 16,
  parameter int MAX_ON_CYC  = 1024,
  parameter int CNT_W       = $clog2(MAX_ON_CYC + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  pump_array_ctrl_if.slave          bus,
  output logic [NUM_PUMPS-1:0]      pump_activated,
  output logic                      fault_irq,
  output logic [NUM_PUMPS-1:0][2:0] chan_state
);

  logic [NUM_PUMPS-1:0] req_q;
  logic [NUM_PUMPS-1:0] fault_q;
  logic [NUM_PUMPS-1:0] enable_q;
  logic [NUM_PUMPS-1:0] wdata;
  logic [NUM_PUMPS-1:0] fault_clr_mask;
  logic [NUM_PUMPS-1:0] go;
  logic [NUM_PUMPS-1:0] on_vec;
  logic [NUM_PUMPS-1:0] fault_set_vec;
  logic [7:0]           rd_val;

  assign wdata          = bus.dataIn[NUM_PUMPS-1:0];
  assign fault_clr_mask = (bus.write && bus.address == ADDR_FAULT) ? wdata : '0;
  assign go             = req_q & enable_q;

  // Channel drive comes straight from each FSM's registered output.
  assign pump_activated = on_vec;

  // Register file: REQ/ENABLE plain RW, FAULT is W1C with set beating clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= REQ_RST[NUM_PUMPS-1:0];
      fault_q  <= FAULT_RST[NUM_PUMPS-1:0];
      enable_q <= ENABLE_RST[NUM_PUMPS-1:0];
    end else begin
      if (bus.write && bus.address == ADDR_REQ)    req_q    <= wdata;
      if (bus.write && bus.address == ADDR_ENABLE) enable_q <= wdata;
      fault_q <= (fault_q & ~fault_clr_mask) | fault_set_vec;
    end
  end

  // Read mux over the pre-write register values; unused bits read as 0.
  always_comb begin
    rd_val = 8'h00;
    case (bus.address)
      ADDR_REQ:    rd_val[NUM_PUMPS-1:0] = req_q;
      ADDR_STATUS: rd_val[NUM_PUMPS-1:0] = on_vec;
      ADDR_FAULT:  rd_val[NUM_PUMPS-1:0] = fault_q;
      ADDR_ENABLE: rd_val[NUM_PUMPS-1:0] = enable_q;
      default:     rd_val = 8'h00;
    endcase
    rd_val = low_bits(rd_val, NUM_PUMPS);
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dataOut <= DOUT_RST;
    end else if (bus.read) begin
      bus.dataOut <= rd_val;
    end
  end

  // Interrupt tracks the OR of the fault flags one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_irq <= 1'b0;
    end else begin
      fault_irq <= |fault_q;
    end
  end

  for (genvar i = 0; i < NUM_PUMPS; i++) begin : g_chan
    chan_state_t ch_state;

    pump_array_ctrl_channel #(
      .MIN_ON_CYC  (MIN_ON_CYC),
      .MIN_OFF_CYC (MIN_OFF_CYC),
      .MAX_ON_CYC  (MAX_ON_CYC),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .go        (go[i]),
      .fault_clr (~fault_q[i]),
      .on        (on_vec[i]),
      .fault_set (fault_set_vec[i]),
      .state     (ch_state)
    );

    assign chan_state[i] = ch_state;
  end

endmodule

// File: tb/tb_pump_array_ctrl.sv
// Directed bench for pump_array_ctrl. Drivers push expected read data and
// expected pin snapshots into queues; monitors on the falling edge pop and
// compare them against the DUT outputs.
module tb_pump_array_ctrl;
  import pump_array_ctrl_pkg::*;

  localparam int NP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pump_array_ctrl_if bus ();
  logic [NP-1:0]      pump_activated;
  logic               fault_irq;
  logic [NP-1:0][2:0] chan_state;

  pump_array_ctrl #(
    .NUM_PUMPS   (NP),
    .MIN_ON_CYC  (16),
    .MIN_OFF_CYC (16),
    .MAX_ON_CYC  (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .pump_activated (pump_activated),
    .fault_irq      (fault_irq),
    .chan_state     (chan_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  string       rd_name_q[$];
  logic [12:0] pin_q[$];      // {dataOut, fault_irq, pump_activated}
  string       pin_name_q[$];
  logic [7:0]  last_rd = 8'h00;
  logic        rd_seen;
  logic [NP-1:0] prev_pumps = '0;

  always @(posedge clk) rd_seen <= bus.read;

  // Read monitor: a read sampled on the last rising edge yields dataOut now.
  always @(negedge clk) begin
    logic [7:0] e;
    string n;
    if (rd_seen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got dataOut=%h, required no read data", bus.dataOut);
      end else begin
        e = exp_q.pop_front();
        n = rd_name_q.pop_front();
        if (bus.dataOut !== e) begin
          failures++;
          $display("FAIL %s: got dataOut=%h required %h at %0t", n, bus.dataOut, e, $time);
        end
      end
    end
  end

  // Pin monitor: compares every snapshot pushed during the current cycle.
  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] a;
    string n;
    while (pin_q.size() > 0) begin
      e = pin_q.pop_front();
      n = pin_name_q.pop_front();
      a = {bus.dataOut, fault_irq, pump_activated};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got dout=%h irq=%b pumps=%b required dout=%h irq=%b pumps=%b at %0t",
                 n, a[12:5], a[4], a[3:0], e[12:5], e[4], e[3:0], $time);
      end
    end
  end

  // Activity log of pump transitions.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (pump_activated[i] !== prev_pumps[i])
        $display("SIM_LOG pump %0d %s at %0t", i,
                 pump_activated[i] ? "activated" : "deactivated", $time);
    end
    prev_pumps = pump_activated;
  end

  // ---------------- driver tasks ----------------
  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.write   = 1'b1;
    bus.address = a;
    bus.dataIn  = d;
    cyc(1);
    bus.write   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] e, input string n);
    bus.read    = 1'b1;
    bus.address = a;
    exp_q.push_back(e);
    rd_name_q.push_back(n);
    last_rd = e;
    cyc(1);
    bus.read = 1'b0;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] e, input string n);
    bus.write   = 1'b1;
    bus.read    = 1'b1;
    bus.address = a;
    bus.dataIn  = d;
    exp_q.push_back(e);
    rd_name_q.push_back(n);
    last_rd = e;
    cyc(1);
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic snap(input logic irq, input logic [NP-1:0] p, input string n);
    pin_q.push_back({last_rd, irq, p});
    pin_name_q.push_back(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    last_rd = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.address = 2'd0;
    bus.dataIn  = 8'h00;

    // Test 1: reset values, activation latency, STATUS, read+write same cycle.
    do_reset();
    snap(1'b0, 4'h0, "t1_reset_pins");
    bus_read(ADDR_REQ,    8'h00, "t1_reset_req");
    bus_read(ADDR_FAULT,  8'h00, "t1_reset_fault");
    bus_read(ADDR_ENABLE, 8'h0F, "t1_reset_enable");
    bus_write(ADDR_REQ, 8'h01);
    snap(1'b0, 4'h0, "t1_not_yet_on");
    cyc(1);
    snap(1'b0, 4'h1, "t1_on_after_one");
    bus_read(ADDR_STATUS, 8'h01, "t1_status");
    bus_rw(ADDR_REQ, 8'h03, 8'h01, "t1_rw_old_value");
    bus_read(ADDR_REQ, 8'h03, "t1_rw_new_value");
    snap(1'b0, 4'h3, "t1_ch1_on");

    // Test 2: early REQ drop honours min-on, early re-request honours min-off.
    do_reset();
    bus_write(ADDR_REQ, 8'h01);
    cyc(1);
    snap(1'b0, 4'h1, "t2_on");
    cyc(1);
    bus_write(ADDR_REQ, 8'h00);
    cyc(13);
    snap(1'b0, 4'h1, "t2_min_on_last");
    cyc(1);
    snap(1'b0, 4'h0, "t2_off_after_16");
    bus_write(ADDR_REQ, 8'h01);
    cyc(14);
    snap(1'b0, 4'h0, "t2_min_off_last");
    cyc(1);
    snap(1'b0, 4'h1, "t2_on_after_16_off");

    // Test 3: run watchdog, fault latch, W1C with 0 ignored, recovery.
    do_reset();
    bus_write(ADDR_REQ, 8'h02);
    cyc(1024);
    snap(1'b0, 4'h2, "t3_last_run_cycle");
    cyc(1);
    snap(1'b0, 4'h0, "t3_watchdog_off");
    bus_read(ADDR_FAULT, 8'h02, "t3_fault_set");
    snap(1'b1, 4'h0, "t3_irq_high");
    cyc(50);
    snap(1'b1, 4'h0, "t3_stays_off");
    bus_write(ADDR_FAULT, 8'h00);
    bus_read(ADDR_FAULT, 8'h02, "t3_w0_no_clear");
    bus_write(ADDR_FAULT, 8'h02);
    snap(1'b1, 4'h0, "t3_irq_lags_clear");
    cyc(1);
    snap(1'b0, 4'h0, "t3_irq_low");
    cyc(15);
    snap(1'b0, 4'h0, "t3_min_off_last");
    cyc(1);
    snap(1'b0, 4'h2, "t3_on_again");

    // Test 4: ENABLE masks channel 0; STATUS is read-only; unused bits ignored.
    do_reset();
    bus_write(ADDR_ENABLE, 8'h0E);
    bus_write(ADDR_REQ, 8'h0F);
    snap(1'b0, 4'h0, "t4_not_yet_on");
    cyc(1);
    snap(1'b0, 4'hE, "t4_ch1_3_on");
    cyc(20);
    snap(1'b0, 4'hE, "t4_ch0_never");
    bus_write(ADDR_STATUS, 8'hFF);
    bus_read(ADDR_STATUS, 8'h0E, "t4_status_ro");
    bus_read(ADDR_ENABLE, 8'h0E, "t4_enable");
    bus_write(ADDR_ENABLE, 8'hFF);
    snap(1'b0, 4'hE, "t4_enable_latency");
    cyc(1);
    snap(1'b0, 4'hF, "t4_ch0_on");
    bus_read(ADDR_ENABLE, 8'h0F, "t4_enable_unused_bits");

    // Test 5: reset mid ON_HOLD clears everything on the next edge.
    do_reset();
    bus_write(ADDR_REQ, 8'h0F);
    cyc(3);
    bus_read(ADDR_STATUS, 8'h0F, "t5_all_on");
    snap(1'b0, 4'hF, "t5_pins_on");
    rst = 1'b1;
    cyc(1);
    last_rd = 8'h00;
    snap(1'b0, 4'h0, "t5_reset_pins");
    rst = 1'b0;
    bus_read(ADDR_REQ,    8'h00, "t5_req_cleared");
    bus_read(ADDR_ENABLE, 8'h0F, "t5_enable_restored");
    cyc(3);
    snap(1'b0, 4'h0, "t5_stays_off");

    // Test 6: W1C on the watchdog edge; the set wins.
    do_reset();
    bus_write(ADDR_REQ, 8'h01);
    cyc(1024);
    snap(1'b0, 4'h1, "t6_last_run_cycle");
    bus_write(ADDR_FAULT, 8'h01);
    snap(1'b0, 4'h0, "t6_watchdog_off");
    cyc(1);
    snap(1'b1, 4'h0, "t6_irq_high");
    bus_read(ADDR_FAULT, 8'h01, "t6_fault_kept");

    // Drain and report.
    cyc(3);
    checks++;
    if (exp_q.size() != 0 || pin_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d reads and %0d snapshots pending, required 0 and 0",
               exp_q.size(), pin_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: got no completion by %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
